mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multi-cycle main control unit for the MIPS32 datapath.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, beq, addi and j.
- Drives the ALUop code consumed by the ALU control decoder:
  - 00 = add (address / PC+4 / addi)
  - 01 = subtract (beq compare)
  - 10 = R-type, decode funct
- Sits between the instruction register opcode field and all datapath mux/enable controls.
- Stalls on a simple memory ready handshake.

Parameters:
- RESET_PC_HOLD, 1, number of idle cycles in S_IDLE after reset release before the first fetch (≥1).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a write (valid only with mem_req)
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load the instruction register
- pc_write  out  1  unconditional PC load
- pc_en  out  1  final PC enable = pc_write | (branch & zero)
- branch  out  1  conditional branch state
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  to the ALU control decoder
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state_dbg  out  4  current state encoding

Behaviour:
- **Reset.** rst_n low at a clock edge puts the FSM in S_IDLE and clears the idle counter. This holds from any state, mid-access included. In S_IDLE every output is 0 and state_dbg = 0. Stay RESET_PC_HOLD cycles, then go to S_FETCH.
- **Output timing.** Outputs are a Moore decode of the state register. The exceptions are ir_write, pc_write and pc_en in S_FETCH, which are qualified by mem_ready. Outputs not listed for a state are 0.
- **S_FETCH (1).**
  - Asserts mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write follow mem_ready.
  - Stays in S_FETCH while mem_ready=0; goes to S_DECODE when mem_ready=1.
- **S_DECODE (2).**
  - Asserts alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 100011 or 101011 → S_MEMADR
    - 000000 → S_REXEC
    - 000100 → S_BEQ
    - 001000 → S_ADDIEX
    - 000010 → S_JUMP
    - other → S_FETCH, with illegal_op pulsed for exactly this one cycle.
- **S_MEMADR (3).** alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw → S_MEMRD, sw → S_MEMWR.
- **S_MEMRD (4).** mem_req=1, iord=1. Hold until mem_ready, then go to S_MEMWB.
- **S_MEMWB (5).** reg_write=1, reg_dst=0, mem_to_reg=1. Next: S_FETCH.
- **S_MEMWR (6).** mem_req=1, mem_write=1, iord=1. Hold until mem_ready, then go to S_FETCH.
- **S_REXEC (7).** alu_src_a=1, alu_src_b=00, alu_op=10. Next: S_RWB.
- **S_RWB (8).** reg_write=1, reg_dst=1, mem_to_reg=0. Next: S_FETCH.
- **S_BEQ (9).**
  - Asserts alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01.
  - pc_en = zero. Next: S_FETCH.
- **S_ADDIEX (10).** alu_src_a=1, alu_src_b=10, alu_op=00. Next: S_ADDIWB.
- **S_ADDIWB (11).** reg_write=1, reg_dst=0, mem_to_reg=0. Next: S_FETCH.
- **S_JUMP (12).** pc_write=1, pc_src=10. Next: S_FETCH.
- **Unused encodings (13–15).** Go to S_FETCH; all outputs 0.
- **Instruction latency with mem_ready tied high:**
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each stall cycle adds one.
- **Opcode sampling.** opcode is sampled only in S_DECODE; changes at any other time are ignored.
- **Mutual exclusion.** mem_write and reg_write are never high together. pc_write and branch are never high together.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state enum (4-bit, values as listed)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUop constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - alu_src_b and pc_src select constants.
- One natural sub-module, mc_ctrl_outdec: purely combinational state → control-word decode. The FSM module keeps the state register, next-state logic, idle counter and handshake qualification.

Test Plan:
- **Reset sequence.** Reset asserted 3 cycles, then released with RESET_PC_HOLD=1 → all outputs 0 while in S_IDLE; state_dbg = 0, 1, 2 on successive cycles; ir_write=1 and pc_write=1 in the S_FETCH cycle (mem_ready=1).
- **lw with stalls.** opcode=100011, mem_ready high except 2 low cycles in S_MEMRD → states 1,2,3,4,4,4,5,1; reg_write=1 with mem_to_reg=1 for exactly one cycle.
- **R-type then beq.**
  - opcode=000000 → alu_op=10 in S_REXEC; reg_dst=1 and reg_write=1 in S_RWB.
  - Then opcode=000100 with zero=1 → alu_op=01, pc_en=1. Repeat with zero=0 → pc_en=0.
- **sw, addi, j.**
  - sw: mem_write=1 and iord=1 only in S_MEMWR; reg_write never high.
  - addi: alu_src_b=10, then reg_dst=0 writeback.
  - j: pc_src=10, pc_write=1, 3-cycle total.
- **Illegal opcode and mid-access reset.**
  - opcode=111111 → illegal_op high exactly one cycle, next state S_FETCH.
  - rst_n low during an S_MEMWR stall → next cycle S_IDLE, mem_req=0, mem_write=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS32 main control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure Moore decode of the control state into the datapath control word.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      // ir_write/pc_write are raw here; the FSM gates them with mem_ready
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 main control: state register, sequencing, idle hold
// after reset and memory-ready qualification of the fetch strobes.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_en,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  localparam int CNT_W = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_PC_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  // lw/sw choice is latched in decode so MEMADR never looks at opcode
  logic             is_sw_q, is_sw_d;
  ctrl_t            ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      is_sw_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      is_sw_q    <= is_sw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    is_sw_d    = is_sw_q;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == HOLD_LAST) begin
          state_d    = S_FETCH;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  logic fetch_gate;
  assign fetch_gate = (state_q != S_FETCH) | mem_ready;

  assign mem_req    = ctrl.mem_req;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write & fetch_gate;
  assign pc_write   = ctrl.pc_write & fetch_gate;
  assign pc_en      = pc_write | (ctrl.branch & zero);
  assign branch     = ctrl.branch;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign state_dbg  = state_q;

endmodule
